// File: rtl/uart_pkg.sv
// Shared types for the UART transmit queue: FSM state encoding and default depth.
package uart_pkg;
   localparam int UART_TXQ_DEPTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_LO,
      WAIT_HI
   } txq_state_t;
endpackage

// File: rtl/sync_fifo_dual_wr.sv
// Byte FIFO with a 1- or 2-byte push port and a 1-byte pop port.
// Acceptance is judged on the occupancy before any same-cycle pop.
module sync_fifo_dual_wr #(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          push2,
   input  logic [15:0]   push_word,
   input  logic          pop,
   input  logic          flush,
   output logic [7:0]    pop_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          ovf
);
   localparam int PW = CW - 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr_p1;
   logic [CW-1:0] add;
   logic [CW-1:0] count_next;
   logic          accept1;
   logic          accept2;
   logic          reject;
   logic          do_pop;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign pop_data  = mem[rd_ptr];
   assign wr_ptr_p1 = wr_ptr + PW'(1);

   always_comb begin
      accept2    = push2 && (count <= CW'(DEPTH - 2));
      accept1    = push && !push2 && !full;
      // a word always wins over a single byte; the dropped byte counts as overflow
      reject     = (push2 && !accept2) || (push && push2) || (push && !push2 && full);
      do_pop     = pop && !empty;
      add        = accept2 ? CW'(2) : (accept1 ? CW'(1) : '0);
      count_next = count + add - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (!flush) begin
         if (accept2) begin
            mem[wr_ptr]    <= push_word[15:8];
            mem[wr_ptr_p1] <= push_word[7:0];
         end else if (accept1) begin
            mem[wr_ptr] <= push_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (accept2)
            wr_ptr <= wr_ptr + PW'(2);
         else if (accept1)
            wr_ptr <= wr_ptr_p1;
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
         if (reject)
            ovf <= 1'b1;
      end
   end
endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue in front of a UART: buffers bytes and hands them one at a time
// to the transmitter using the trmt strobe / tx_done handshake.
//
// state   | meaning
// IDLE    | waiting for queued data and an idle transmitter
// LAUNCH  | one cycle: trmt high, tx_data valid, byte popped
// WAIT_LO | frame launched, waiting for tx_done to drop
// WAIT_HI | frame in progress, waiting for tx_done to rise
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_TXQ_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          wr16_en,
   input  logic [15:0]   wr_word,
   input  logic          flush,
   input  logic          tx_done,
   output logic          trmt,
   output logic [7:0]    tx_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          busy,
   output logic          ovf
);
   txq_state_t state;
   txq_state_t state_next;
   logic       load;
   logic       pop;
   logic [7:0] pop_data;

   sync_fifo_dual_wr #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wr_en),
      .push_data (wr_data),
      .push2     (wr16_en),
      .push_word (wr_word),
      .pop       (pop),
      .flush     (flush),
      .pop_data  (pop_data),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .ovf       (ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      unique case (state)
         IDLE: begin
            // a flush in the same cycle empties the queue, so no launch
            if (!empty && tx_done && !flush) begin
               state_next = LAUNCH;
               load       = 1'b1;
            end
         end
         LAUNCH:  state_next = WAIT_LO;
         WAIT_LO: if (!tx_done) state_next = WAIT_HI;
         WAIT_HI: if (tx_done)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign trmt = (state == LAUNCH);
   assign pop  = (state == LAUNCH);
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tx_data <= 8'h00;
      else if (load)
         tx_data <= pop_data;
   end
endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, 8, FIFO depth in bytes (power of 2, 4..64); CW, $clog2(DEPTH)+1, occupancy count width.
REQ-002 clk input 1 system clock; all state updates on posedge.
REQ-003 rst_n input 1 reset, asynchronous, active-low.
REQ-004 wr_en input 1 single-cycle request to push wr_data.
REQ-005 wr_data input 8 byte to queue.
REQ-006 wr16_en input 1 single-cycle request to push wr_word as two bytes, high byte first.
REQ-007 wr_word input 16 word to queue.
REQ-008 flush input 1 discard all queued bytes.
REQ-009 tx_done input 1 transmitter status; high = transmitter idle, low = frame in progress.
REQ-010 trmt output 1 single-cycle transmit strobe to the transmitter.
REQ-011 tx_data output 8 byte presented with trmt; held stable until the next trmt.
REQ-012 full output 1 count == DEPTH.
REQ-013 empty output 1 count == 0.
REQ-014 count output CW bytes currently queued, excluding the byte in flight.
REQ-015 busy output 1 high whenever state != IDLE.
REQ-016 ovf output 1 sticky overflow flag; cleared only by flush or reset.

Function
REQ-017 Storage SHALL be a circular buffer with wr_ptr/rd_ptr of width CW-1; pointers wrap from DEPTH-1 to 0.
REQ-018 wr_en with !full SHALL store wr_data at wr_ptr and increment count at the next edge.
REQ-019 wr16_en with count <= DEPTH-2 SHALL store wr_word[15:8] then wr_word[7:0] in consecutive slots in the same cycle; count +2.
REQ-020 Write rejection: wr_en when full, or wr16_en when count > DEPTH-2, SHALL store nothing, set ovf, and leave count unchanged; a word is never partially written.
REQ-021 wr_en and wr16_en together: wr16_en SHALL take priority, wr_en is dropped and ovf is set.
REQ-022 FSM states SHALL be IDLE, LAUNCH, WAIT_LO, WAIT_HI.
REQ-023 IDLE -> LAUNCH when !empty and tx_done == 1; otherwise remain in IDLE.
REQ-024 LAUNCH (one cycle): assert trmt, drive tx_data = buffer[rd_ptr], advance rd_ptr, decrement count; -> WAIT_LO.
REQ-025 WAIT_LO -> WAIT_HI when tx_done == 0; WAIT_HI -> IDLE when tx_done == 1.
REQ-026 Back-to-back frames: minimum gap SHALL be one IDLE cycle between tx_done rising and the next trmt.
REQ-027 Simultaneous write and LAUNCH pop SHALL be applied together: count changes by (+1 or +2) - 1; full and empty are computed from the resulting count.
REQ-028 Write into a full FIFO during the LAUNCH cycle SHALL still be rejected; full is evaluated before the pop.
REQ-029 flush SHALL zero pointers, count, and ovf at the next edge and override any write in the same cycle; a frame already launched completes and the FSM follows tx_done normally.
REQ-030 trmt SHALL never be asserted outside LAUNCH; at most one trmt per tx_done low/high cycle.

Reset
REQ-031 Reset SHALL force: state IDLE, pointers 0, count 0, trmt 0, tx_data 8'h00, ovf 0, empty 1, full 0, busy 0.
REQ-032 Buffer contents SHALL not be reset.
REQ-033 Reset asserted mid-frame SHALL return the block to IDLE; it SHALL NOT wait for tx_done.

Structure
REQ-034 Shared package uart_pkg SHALL hold the state enum (txq_state_t) and the default depth constant UART_TXQ_DEPTH = 8.
REQ-035 Storage and pointers SHALL be a sub-module sync_fifo_dual_wr (1- or 2-byte push, 1-byte pop); uart_tx_queue holds the FSM and transmitter handshake.

Verification
REQ-036 Reset, then wr_en 8'hA5 with tx_done = 1 -> trmt pulses 2 cycles later with tx_data = 8'hA5; count returns to 0; busy stays high until tx_done returns to 1.
REQ-037 wr16_en 16'h12C4 -> two frames in order, 8'h12 then 8'hC4; each trmt follows tx_done rising by exactly 2 cycles.
REQ-038 Fill to 8 bytes with tx_done held 0, then one more wr_en -> full = 1, ovf = 1, count = 8; the ninth byte never appears on tx_data.
REQ-039 count = 7, then wr16_en -> rejected, ovf = 1, count = 7; in the LAUNCH cycle with count = 8, wr_en -> rejected.
REQ-040 flush with 5 bytes queued during WAIT_LO -> count = 0, empty = 1, ovf = 0; the current frame finishes; no further trmt.
REQ-041 rst_n asserted in WAIT_HI with 3 bytes queued -> after release: IDLE, count = 0, trmt = 0.
